// File: rtl/gpio_pad_ctrl.sv
// Core-side GPIO controller for the left-bank pad wrapper: registered output/direction,
// synchronised and tick-sampled glitch filter on pad inputs, sticky W1C edge interrupts.
module gpio_pad_ctrl #(
  parameter int NPADS = 19,
  parameter int DIV_W = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_tick_div,
  input  logic [NPADS-1:0] pad_gpio_in,
  output logic [NPADS-1:0] pad_gpio_out,
  output logic [NPADS-1:0] pad_gpio_oeb,
  input  logic [NPADS-1:0] core_dout,
  input  logic [NPADS-1:0] core_oe,
  output logic [NPADS-1:0] core_din,
  input  logic [NPADS-1:0] intr_rise_en,
  input  logic [NPADS-1:0] intr_fall_en,
  input  logic [NPADS-1:0] intr_clr,
  output logic [NPADS-1:0] intr_stat,
  output logic             gpio_intr
);

  logic [NPADS-1:0] sync_p0, sync_p1;
  logic [NPADS-1:0] smp_p0, smp_p1, smp_p2;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [NPADS-1:0] din_next, rise, fall, stat_next;

  // A pad only takes the sampled level once all three samples agree; otherwise it holds.
  function automatic logic [NPADS-1:0] vote3(input logic [NPADS-1:0] a,
                                             input logic [NPADS-1:0] b,
                                             input logic [NPADS-1:0] c,
                                             input logic [NPADS-1:0] hold);
    logic [NPADS-1:0] agree;
    agree = ~(a ^ b) & ~(b ^ c);
    return (agree & a) | (~agree & hold);
  endfunction

  // Equality compare only: lowering the divisor below tick_cnt lets it wrap instead of firing early.
  assign tick = (tick_cnt == cfg_tick_div);

  always_comb begin
    din_next  = vote3(smp_p0, smp_p1, smp_p2, core_din);
    rise      = din_next & ~core_din;
    fall      = ~din_next & core_din;
    stat_next = (intr_stat & ~intr_clr) | (rise & intr_rise_en) | (fall & intr_fall_en);
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      pad_gpio_out <= '0;
      pad_gpio_oeb <= '1;
      sync_p0      <= '0;
      sync_p1      <= '0;
      tick_cnt     <= '0;
      smp_p0       <= '0;
      smp_p1       <= '0;
      smp_p2       <= '0;
      core_din     <= '0;
      intr_stat    <= '0;
      gpio_intr    <= 1'b0;
    end else begin
      // output stage: one register between core and pad wrapper
      pad_gpio_out <= core_dout;
      pad_gpio_oeb <= ~core_oe;
      // synchroniser stage
      sync_p0      <= pad_gpio_in;
      sync_p1      <= sync_p0;
      // sample stage
      tick_cnt     <= tick ? '0 : tick_cnt + DIV_W'(1);
      if (tick) begin
        smp_p2 <= smp_p1;
        smp_p1 <= smp_p0;
        smp_p0 <= sync_p1;
      end
      // filter and interrupt stage
      core_din     <= din_next;
      intr_stat    <= stat_next;
      gpio_intr    <= |stat_next;
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: expectations are queued as stimulus is applied and
// compared against the DUT outputs when they become due.
module tb_gpio_pad_ctrl;
  localparam int NPADS = 19;
  localparam int DIV_W = 16;

  logic             mclk = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] cfg_tick_div;
  logic [NPADS-1:0] pad_gpio_in, pad_gpio_out, pad_gpio_oeb;
  logic [NPADS-1:0] core_dout, core_oe, core_din;
  logic [NPADS-1:0] intr_rise_en, intr_fall_en, intr_clr, intr_stat;
  logic             gpio_intr;

  gpio_pad_ctrl #(.NPADS(NPADS), .DIV_W(DIV_W)) dut (
    .mclk(mclk), .reset(reset), .cfg_tick_div(cfg_tick_div),
    .pad_gpio_in(pad_gpio_in), .pad_gpio_out(pad_gpio_out), .pad_gpio_oeb(pad_gpio_oeb),
    .core_dout(core_dout), .core_oe(core_oe), .core_din(core_din),
    .intr_rise_en(intr_rise_en), .intr_fall_en(intr_fall_en), .intr_clr(intr_clr),
    .intr_stat(intr_stat), .gpio_intr(gpio_intr)
  );

  always #5 mclk = ~mclk;

  localparam int S_OUT = 0, S_OEB = 1, S_DIN = 2, S_STAT = 3, S_INTR = 4;

  typedef struct {
    string            tag;
    int               sel;
    logic [NPADS-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NPADS-1:0] observe(input int sel);
    case (sel)
      S_OUT:   return pad_gpio_out;
      S_OEB:   return pad_gpio_oeb;
      S_DIN:   return core_din;
      S_STAT:  return intr_stat;
      default: return {{(NPADS-1){1'b0}}, gpio_intr};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [NPADS-1:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic drain();
    exp_t             e;
    logic [NPADS-1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic push_reset_vals(input string pfx);
    push({pfx, "_out"},  S_OUT,  '0);
    push({pfx, "_oeb"},  S_OEB,  '1);
    push({pfx, "_din"},  S_DIN,  '0);
    push({pfx, "_stat"}, S_STAT, '0);
    push({pfx, "_intr"}, S_INTR, '0);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  found;

    reset = 1'b1; cfg_tick_div = '0; pad_gpio_in = '0;
    core_dout = '0; core_oe = '0;
    intr_rise_en = '0; intr_fall_en = '0; intr_clr = '0;
    step(3);
    push_reset_vals("in_reset");
    reset = 1'b0;
    step(3);
    push_reset_vals("idle");

    // output path, one cycle latency
    core_oe = 19'h00005; core_dout = 19'h00004;
    step(1);
    push("oeb_drive", S_OEB, 19'h7FFFA);
    push("out_drive", S_OUT, 19'h00004);
    push("din_unaffected", S_DIN, '0);
    drain();
    core_oe = '0; core_dout = '0;
    step(1);
    push("oeb_release", S_OEB, 19'h7FFFF);
    push("out_release", S_OUT, '0);
    drain();

    // rising edge on pad 3 with tick every cycle: visible at edge 6
    intr_rise_en = 19'h00008;
    pad_gpio_in  = 19'h00008;
    step(5);
    push("rise3_e5_din",  S_DIN,  '0);
    push("rise3_e5_stat", S_STAT, '0);
    push("rise3_e5_intr", S_INTR, '0);
    drain();
    step(1);
    push("rise3_e6_din",  S_DIN,  19'h00008);
    push("rise3_e6_stat", S_STAT, 19'h00008);
    push("rise3_e6_intr", S_INTR, 19'h1);
    drain();

    intr_clr = 19'h00008;
    step(1);
    intr_clr = '0;
    push("clr3_stat", S_STAT, '0);
    push("clr3_intr", S_INTR, '0);
    push("clr3_din",  S_DIN,  19'h00008);
    drain();

    // 2-cycle glitch on pad 0 must be rejected
    intr_rise_en = 19'h00009;
    pad_gpio_in  = 19'h00009;
    step(2);
    pad_gpio_in  = 19'h00008;
    for (int i = 0; i < 12; i++) begin
      step(1);
      push("glitch_din",  S_DIN,  19'h00008);
      push("glitch_stat", S_STAT, '0);
      drain();
    end

    // falling edge on pad 7 coinciding with a clear: set wins
    intr_fall_en = 19'h00080;
    pad_gpio_in  = 19'h00088;
    step(8);
    push("p7_high_din",  S_DIN,  19'h00088);
    push("p7_high_stat", S_STAT, '0);
    drain();
    pad_gpio_in = 19'h00008;
    step(5);
    push("p7_pre_fall_din",  S_DIN,  19'h00088);
    push("p7_pre_fall_stat", S_STAT, '0);
    drain();
    intr_clr = 19'h00080;
    step(1);
    intr_clr = '0;
    push("p7_setwins_din",  S_DIN,  19'h00008);
    push("p7_setwins_stat", S_STAT, 19'h00080);
    push("p7_setwins_intr", S_INTR, 19'h1);
    drain();
    intr_fall_en = '0;
    step(1);
    push("p7_en_off_stat", S_STAT, 19'h00080);
    push("p7_en_off_intr", S_INTR, 19'h1);
    drain();
    intr_clr = 19'h00080;
    step(1);
    intr_clr = '0;
    push("p7_clr_stat", S_STAT, '0);
    push("p7_clr_intr", S_INTR, '0);
    drain();

    // divided tick (period 4): pad 0 needs three ticks after sync
    cfg_tick_div = 16'd3;
    pad_gpio_in  = 19'h00009;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step(1);
      if (core_din[0]) begin n = i; found = 1'b1; end
    end
    checks++;
    assert (found && n >= 12 && n <= 15) else begin
      errors++;
      $error("FAIL div3_rise_latency: observed %0d cycles (found=%0d) expected 12..15", n, found);
    end
    push("div3_rise_din",  S_DIN,  19'h00009);
    push("div3_rise_stat", S_STAT, 19'h00001);
    push("div3_rise_intr", S_INTR, 19'h1);
    drain();
    intr_clr = 19'h00001;
    step(1);
    intr_clr = '0;
    push("div3_clr_stat", S_STAT, '0);
    drain();
    pad_gpio_in = 19'h00008;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step(1);
      if (!core_din[0]) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL div3_fall_timeout: observed din %h expected bit0 clear within 40 cycles", core_din);
    end
    push("div3_fall_stat", S_STAT, '0);
    drain();
    pad_gpio_in = 19'h00009;
    step(8);
    pad_gpio_in = 19'h00008;
    for (int i = 0; i < 40; i++) begin
      step(1);
      push("div3_pulse_din",  S_DIN,  19'h00008);
      push("div3_pulse_stat", S_STAT, '0);
      drain();
    end

    // realign the divider, then reset mid-filter with smp = 3'b011 on pad 2
    cfg_tick_div = '0;
    pad_gpio_in  = '0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_reset_vals("realign");
    intr_rise_en = '1;
    intr_fall_en = '1;
    pad_gpio_in  = 19'h00004;
    core_oe = 19'h00003; core_dout = 19'h00003;
    step(4);
    reset = 1'b1;
    pad_gpio_in = '0;
    step(1);
    push_reset_vals("mid_reset");
    reset = 1'b0;
    core_oe = '0; core_dout = '0;
    step(12);
    push("post_reset_din",  S_DIN,  '0);
    push("post_reset_stat", S_STAT, '0);
    push("post_reset_intr", S_INTR, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
